// File: rtl/flag_branch_unit.sv
// Purpose: architectural Z/V/N flag register fed by the EX-stage ALU, plus the branch-condition evaluator for ID and branch/taken counters.
// Latency: a flag write shows on `flags` one cycle after the EX edge, and a branch in ID sees it in the same cycle through forwarding.
// Backpressure: none. `stall` freezes flag writes and counting, and `flush` squashes the EX write and its forwarding.
// Ports: clk/rst_n (rising edge, async active-low reset); ex_valid/ex_opcode/alu_{z,v,n} (EX instruction and its ALU flags);
//        stall/flush (pipeline control); br_valid/br_cond (branch in ID); flags ({Z,V,N} register); br_taken (combinational decision);
//        flags_upd (registered write pulse); br_count/taken_count (wrapping performance counters).
module flag_branch_unit #(
  parameter int         CNT_W       = 16,
  parameter logic [2:0] RESET_FLAGS = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid,
  input  logic [2:0]       br_cond,
  output logic [2:0]       flags,
  output logic             br_taken,
  output logic             flags_upd,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  // Opcodes that touch flags; every other opcode leaves them alone.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // Branch condition codes.
  localparam logic [2:0] C_NE   = 3'b000;
  localparam logic [2:0] C_EQ   = 3'b001;
  localparam logic [2:0] C_GT   = 3'b010;
  localparam logic [2:0] C_LT   = 3'b011;
  localparam logic [2:0] C_GTE  = 3'b100;
  localparam logic [2:0] C_LTE  = 3'b101;
  localparam logic [2:0] C_OVFL = 3'b110;

  // State is held in {Z,V,N} order. Bit 2 is Z, bit 1 is V and bit 0 is N.
  logic [2:0]       flags_q, flags_d;
  logic             flags_upd_q, flags_upd_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  logic [2:0] upd_mask;
  logic [2:0] alu_flags;
  logic [2:0] merged;
  logic [2:0] eff;
  logic       fwd_en;
  logic       wr;
  logic       cond_ok;
  logic       cnt_en;

  always_comb begin
    upd_mask = 3'b000;
    case (ex_opcode)
      OP_ADD, OP_SUB:                 upd_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_mask = 3'b100;
      default:                        upd_mask = 3'b000;
    endcase
  end

  assign alu_flags = {alu_z, alu_v, alu_n};
  assign merged    = (upd_mask & alu_flags) | (~upd_mask & flags_q);

  // Only flush gates forwarding. A stalled branch keeps re-evaluating
  // against the EX result it will eventually see committed.
  assign fwd_en = ex_valid & ~flush & (upd_mask != 3'b000);
  assign wr     = fwd_en & ~stall;
  assign eff    = fwd_en ? merged : flags_q;

  always_comb begin
    cond_ok = 1'b1;
    case (br_cond)
      C_NE:    cond_ok = ~eff[2];
      C_EQ:    cond_ok = eff[2];
      C_GT:    cond_ok = ~eff[2] & ~eff[0];
      C_LT:    cond_ok = eff[0];
      C_GTE:   cond_ok = eff[2] | (~eff[2] & ~eff[0]);
      C_LTE:   cond_ok = eff[0] | eff[2];
      C_OVFL:  cond_ok = eff[1];
      default: cond_ok = 1'b1;
    endcase
  end

  assign br_taken = br_valid & cond_ok;

  // A branch held in ID across a stall is counted once, on its release edge.
  assign cnt_en = br_valid & ~stall & ~flush;

  always_comb begin
    flags_d       = wr ? merged : flags_q;
    flags_upd_d   = wr;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (cnt_en) begin
      br_count_d = br_count_q + CNT_W'(1);
      if (br_taken) begin
        taken_count_d = taken_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= RESET_FLAGS;
      flags_upd_q   <= 1'b0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      flags_q       <= flags_d;
      flags_upd_q   <= flags_upd_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign flags       = flags_q;
  assign flags_upd   = flags_upd_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule
